tower_mac_stream: RTL
=====================

Name: tower_mac_stream

Overview:
- Streaming multiply-accumulate over the binary tower field T_LOG_W, with W = 2^LOG_W bits. This is the parametrised successor to the fixed 8-bit combinational tower multiplier.
- Accepts a stream of (a, b) pairs with valid/ready, multiplies each pair in a PIPE-stage pipeline and XOR-accumulates the products.
- On the beat marked last it emits the inner product sum(a_i*b_i). This is the per-round evaluation primitive of the sumcheck prover.

Parameters:
- LOG_W, 3, tower level; W = 2^LOG_W (legal 1..7, i.e. 2..128 bits).
- PIPE, 2, register stages inside the multiplier (legal 0..LOG_W).
- CNT_W, 16, width of the term counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_a  in  W  operand a, tower basis
- in_b  in  W  operand b, tower basis
- in_last  in  1  final term of the current sum
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  W  accumulated inner product
- out_count  out  CNT_W  number of terms in out_sum (present only with TOWER_MAC_COUNT_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Field definition:
  - T_0 = GF(2).
  - T_{k+1} = T_k[X_k]/(X_k^2 + X_{k-1}*X_k + 1), with X_{-1} = 1.
  - Element = lo + hi*X_k; lo is the low half of the bits, hi the high half.
- Product in T_{k+1}:
  - lo = a_lo*b_lo ^ a_hi*b_hi
  - hi = a_lo*b_hi ^ a_hi*b_lo ^ (a_hi*b_hi)*X_{k-1}
  - Recurse down to T_0 AND. Implementation may use Karatsuba sharing; only the result is normative.
  - Multiplication by X_{k-1} is itself the tower product with constant X_{k-1}.
- Pipeline: each stage carries {product/partial products, last, valid}. PIPE=0 means the product is combinational into the accumulator.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, all pipeline stages and the accumulator hold.
- Accumulator stage: when a valid product p leaves the pipeline and ~stall:
  - s = acc ^ p.
  - If last: out_sum <= s, out_valid <= 1, acc <= 0.
  - Else: acc <= s.
- Output handshake:
  - out_valid clears on out_valid & out_ready, unless a new last product completes in the same cycle; in that case out_valid stays 1 with the new sum.
  - out_sum is stable while out_valid & ~out_ready.
- Latency: last beat accepted at cycle t -> out_valid at t+PIPE+1. Throughput is one beat per cycle when out_ready=1.
- Back-to-back sums: a beat following a last beat starts a fresh sum with acc = 0. No bubble is required.
- A sum of one term (in_last on the first beat) yields out_sum = a*b.
- Reset:
  - out_valid = 0, out_sum = 0, acc = 0, all stage valids = 0, out_count = 0.
  - in_ready = 1 after reset.
  - Reset mid-sum discards all in-flight beats and the partial accumulator.
- No beat is dropped or duplicated under any out_ready pattern.

Optional Feature:
- Macro: TOWER_MAC_COUNT_EN.
- Defined:
  - Adds the out_count port and a term counter, incremented per product entering the accumulator.
  - Saturates at 2^CNT_W-1.
  - Latched into out_count with out_sum on last; the counter restarts at 0.
- Undefined: no counter, no out_count port; area and behaviour are otherwise identical.

Test Plan:
- LOG_W=3: single beats with last: (0x01,0xA5)->0xA5; (0x02,0x02)->0x03; (0x04,0x04)->0x09; (0x10,0x10)->0x41. Each arrives PIPE+1 cycles after acceptance.
- Stream (0x01,0x5A),(0x02,0x02),(0x01,0x0F,last) -> out_sum=0x56, exactly one out_valid pulse. The next stream (0x01,0x33,last) -> 0x33, proving the accumulator cleared.
- Backpressure: out_ready=0 for 5 cycles while two sums complete -> in_ready=0 during stall, first out_sum held stable. On release the sums appear in order, with no loss.
- Random 1000-beat streams at W=8,16,128 and PIPE=0,2 with random in_valid/out_ready -> sums match a recursive software tower model.
- Assert rst mid-sum after beats (0x02,0x02),(0x01,0x0F) -> out_valid=0 immediately. Post-reset stream (0x01,0x5A,last) -> 0x5A.
- With TOWER_MAC_COUNT_EN and CNT_W=2: 5-term sum -> out_count=3 (saturated). Following 2-term sum -> out_count=2.

Source files
------------

// File: rtl/tower_mac_stream.sv
// Streaming GF(2^(2^LOG_W)) tower-field multiply-accumulate; emits the inner product on the last beat.
// Latency: last beat accepted in cycle t -> out_valid in cycle t+PIPE+1; one beat per cycle when out_ready=1.
// Backpressure: a held result (out_valid & ~out_ready) freezes every stage and deasserts in_ready.
// Optional term counter / out_count port: define TOWER_MAC_COUNT_EN.

// Multiply an element of T_LOG_W by its own generator X_{LOG_W-1} (X_{-1} = 1).
// With v = lo + hi*X:  v*X = hi + (lo + hi*X_{LOG_W-2})*X, so only one recursion per level.
module tower_mulx #(
    parameter int LOG_W = 1
) (
    input  logic [(1<<LOG_W)-1:0] v_i,
    output logic [(1<<LOG_W)-1:0] p_o
);
    generate
        if (LOG_W == 0) begin : g_leaf
            assign p_o = v_i;
        end else begin : g_node
            localparam int H = (1 << LOG_W) / 2;
            logic [H-1:0] hi_x;
            tower_mulx #(.LOG_W(LOG_W-1)) u_mulx (.v_i(v_i[2*H-1:H]), .p_o(hi_x));
            assign p_o = {v_i[H-1:0] ^ hi_x, v_i[2*H-1:H]};
        end
    endgenerate
endmodule

// Combinational tower product in T_LOG_W, Karatsuba form (three half-width products per level).
module tower_mul #(
    parameter int LOG_W = 1
) (
    input  logic [(1<<LOG_W)-1:0] a_i,
    input  logic [(1<<LOG_W)-1:0] b_i,
    output logic [(1<<LOG_W)-1:0] p_o
);
    generate
        if (LOG_W == 0) begin : g_leaf
            assign p_o = a_i & b_i;
        end else begin : g_node
            localparam int H = (1 << LOG_W) / 2;
            logic [H-1:0] ll, hh, mm, hh_x;
            tower_mul  #(.LOG_W(LOG_W-1)) u_ll (.a_i(a_i[H-1:0]),   .b_i(b_i[H-1:0]),   .p_o(ll));
            tower_mul  #(.LOG_W(LOG_W-1)) u_hh (.a_i(a_i[2*H-1:H]), .b_i(b_i[2*H-1:H]), .p_o(hh));
            tower_mul  #(.LOG_W(LOG_W-1)) u_mm (.a_i(a_i[H-1:0] ^ a_i[2*H-1:H]),
                                               .b_i(b_i[H-1:0] ^ b_i[2*H-1:H]), .p_o(mm));
            tower_mulx #(.LOG_W(LOG_W-1)) u_hx (.v_i(hh), .p_o(hh_x));
            // (al+ah)(bl+bh) - al*bl - ah*bh leaves the cross terms al*bh + ah*bl
            assign p_o = {mm ^ ll ^ hh ^ hh_x, ll ^ hh};
        end
    endgenerate
endmodule

module tower_mac_stream #(
    parameter int LOG_W = 3,
    parameter int PIPE  = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [(1<<LOG_W)-1:0]  in_a,
    input  logic [(1<<LOG_W)-1:0]  in_b,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [(1<<LOG_W)-1:0]  out_sum
`ifdef TOWER_MAC_COUNT_EN
    ,
    output logic [CNT_W-1:0]       out_count
`endif
);
    localparam int W = 1 << LOG_W;

    generate
        if (LOG_W < 1 || LOG_W > 7 || PIPE < 0 || PIPE > LOG_W || CNT_W < 1) begin : g_bad_cfg
            $error("tower_mac_stream: illegal LOG_W/PIPE/CNT_W combination");
        end
    endgenerate

    logic         stall;
    logic [W-1:0] prod;
    logic [W-1:0] p_dat;
    logic         p_last;
    logic         p_vld;

    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] out_sum_q, out_sum_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] sum_s;

    // A result nobody has taken yet blocks the whole datapath, so nothing can be overwritten.
    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    tower_mul #(.LOG_W(LOG_W)) u_mul (.a_i(in_a), .b_i(in_b), .p_o(prod));

    // The product is formed up front and then delayed PIPE stages; retiming moves these
    // registers into the multiplier tree, and only the cycle count is visible outside.
    generate
        if (PIPE == 0) begin : g_comb
            assign p_dat  = prod;
            assign p_last = in_last;
            assign p_vld  = in_valid;
        end else begin : g_pipe
            logic [PIPE-1:0][W-1:0] dat_q;
            logic [PIPE-1:0]        last_q;
            logic [PIPE-1:0]        vld_q;

            // Shift the product pipeline forward one stage whenever the output is not held.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dat_q  <= '0;
                    last_q <= '0;
                    vld_q  <= '0;
                end else if (!stall) begin
                    dat_q[0]  <= prod;
                    last_q[0] <= in_last;
                    vld_q[0]  <= in_valid;
                    for (int i = 1; i < PIPE; i++) begin
                        dat_q[i]  <= dat_q[i-1];
                        last_q[i] <= last_q[i-1];
                        vld_q[i]  <= vld_q[i-1];
                    end
                end
            end

            assign p_dat  = dat_q[PIPE-1];
            assign p_last = last_q[PIPE-1];
            assign p_vld  = vld_q[PIPE-1];
        end
    endgenerate

    // Fold each arriving product into the running sum; a last product publishes and restarts it.
    always_comb begin
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        sum_s       = acc_q ^ p_dat;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // A new completion in the same cycle as a handoff keeps out_valid high with the new sum.
        if (p_vld && !stall) begin
            if (p_last) begin
                out_sum_d   = sum_s;
                out_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = sum_s;
            end
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

`ifdef TOWER_MAC_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [CNT_W-1:0] cnt_inc;

    // Count terms alongside the accumulator, saturating rather than wrapping.
    always_comb begin
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (p_vld && !stall) begin
            if (p_last) begin
                out_count_d = cnt_inc;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // Term counter and published count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            out_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_count = out_count_q;
`endif

endmodule
